register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Bank of 16 independent 32-bit registers with a shared data input and a 16-bit per-register write-enable vector.
- All 16 register contents are continuously exposed on dedicated outputs.
- Sits between the instruction decode/write-back path and the ALU operand muxes. An upstream decoder produces `select`; downstream muxes pick from q0..q15.

Parameters:
- WIDTH, 32, data width of each register and of Din.
- NREGS, 16, number of registers. Fixed at 16 because ports q0..q15 are explicit; select width equals NREGS.

Ports:
- clk  input  1  rising-edge clock for all registers
- rst  input  1  synchronous, active-high reset
- select  input  16  write-enable vector; bit i enables a write to register i
- Din  input  32  write data, shared by all registers
- q0  output  32  current contents of register 0
- q1 .. q15  output  32 each  current contents of registers 1..15; qi holds register i

Behaviour:
- Clocking: all state updates on the rising edge of clk only. No combinational path from Din or select to any q.
- Reset:
  - On a rising edge with rst=1, every register (q0..q15) becomes 32'h0000_0000.
  - rst has priority over select; writes in that cycle are discarded.
  - Deasserting rst mid-stream resumes normal operation at the next edge.
- Write: on a rising edge with rst=0, for each i in 0..15, if select[i]=1 then register i <= Din, else register i holds.
- Multi-hot select: every register whose bit is set loads the same Din value on the same edge. This is legal and required behaviour, not an error.
- select = 16'h0000: all registers hold (idle cycle).
- Latency: a written value is visible on qi immediately after the capturing edge (one-cycle write latency). Reads are combinational views of register state with zero latency.
- Power-up: contents are undefined until the first reset edge. The system must apply rst before use.
- No read ports, no bypass/forwarding, no hardwired-zero register. Register 0 is an ordinary writable register.
- Din and select are sampled only at the clock edge. Changes between edges have no effect.

Decomposition:
- Shared package (e.g. regbank_pkg):
  - constants WIDTH=32 and NREGS=16
  - typedef for a 32-bit data word
  - typedef for the 16-bit select vector
- One natural sub-module, bank_reg_cell:
  - a single WIDTH-bit register with clk, rst (sync, active-high), en, d, q
  - instantiated 16 times with en = select[i], d = Din, q = qi
- Top level is pure wiring of the 16 cells.

Test Plan:
- Reset: drive rst=1 with select=16'hFFFF, Din=32'hFFFF_FFFF for one edge -> all q0..q15 = 0; the write is suppressed.
- Single writes: rst=0, select=16'h0001, Din=10 -> after edge q0=10, others 0. Then select=16'h0002, Din=11 -> q1=11, q0 still 10.
- Hold/no-write and sampling: select=16'h0000, Din=32'h1234_5678 for several edges -> all registers unchanged. Change Din between edges with select[3]=1 -> only the value present at the edge is captured into q3.
- Multi-hot: select=16'h0003, Din=13 -> q0=q1=13, other registers unchanged. Then select=16'hFFFF, Din=32'hDEAD_BEEF -> all 16 outputs = 32'hDEAD_BEEF.
- Top index and walking-one: for i=0..15, select=1<<i, Din=100+i -> qi=100+i after each edge. At the end q15=115 and every qj=100+j.
- Reset mid-operation: after the walking-one load, assert rst=1 with select=16'h0010, Din=7 -> all outputs 0 and q4 does not take 7. Deassert rst, select=16'h0010, Din=7 -> q4=7 on the next edge.

Source files
------------

// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_pkg
// Description : Shared constants and types for the 16 x 32-bit register bank.
//               WIDTH - data width of each register and of Din
//               NREGS - number of registers (equals the select width)
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package register_bank_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [NREGS-1:0] sel_t;

endpackage : register_bank_pkg
`default_nettype wire

// File: rtl/register_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_if
// Description : Bus bundle between the write-back path and the register bank.
// Ports       : select - per-register write-enable vector (master -> bank)
//               Din    - shared write data (master -> bank)
//               q0..q15 - register contents (bank -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface register_bank_if;
  import register_bank_pkg::*;

  sel_t  select;
  word_t Din;
  word_t q0, q1, q2, q3, q4, q5, q6, q7;
  word_t q8, q9, q10, q11, q12, q13, q14, q15;

  modport master (
    output select, Din,
    input  q0, q1, q2, q3, q4, q5, q6, q7,
           q8, q9, q10, q11, q12, q13, q14, q15
  );

  modport slave (
    input  select, Din,
    output q0, q1, q2, q3, q4, q5, q6, q7,
           q8, q9, q10, q11, q12, q13, q14, q15
  );

endinterface : register_bank_if
`default_nettype wire

// File: rtl/register_bank_reg_cell.sv
`default_nettype none
// ============================================================================
// Module      : bank_reg_cell
// Description : One WIDTH-bit register with synchronous active-high reset
//               and load enable. Reset wins over enable.
// Ports       : clk - rising-edge clock
//               rst - synchronous active-high reset
//               en  - load enable
//               d   - load data
//               q   - registered contents
// Revision    : 1.0 - initial release
// ============================================================================
module bank_reg_cell
  import register_bank_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  en,
  input  wire word_t d,
  output word_t      q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : bank_reg_cell
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module      : register_bank
// Description : Bank of NREGS independent WIDTH-bit registers sharing one
//               data input; bit i of select loads register i. Any number of
//               select bits may be set at once. All contents are exposed.
// Ports       : clk     - rising-edge clock
//               rst     - synchronous active-high reset (priority over writes)
//               bus     - slave side of register_bank_if
//                         (select, Din in; q0..q15 out)
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank
  import register_bank_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  register_bank_if.slave  bus
);

  word_t q_arr [NREGS];

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    bank_reg_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (bus.select[i]),
      .d   (bus.Din),
      .q   (q_arr[i])
    );
  end

  // The interface exposes individually named outputs, so map the array out.
  assign bus.q0  = q_arr[0];
  assign bus.q1  = q_arr[1];
  assign bus.q2  = q_arr[2];
  assign bus.q3  = q_arr[3];
  assign bus.q4  = q_arr[4];
  assign bus.q5  = q_arr[5];
  assign bus.q6  = q_arr[6];
  assign bus.q7  = q_arr[7];
  assign bus.q8  = q_arr[8];
  assign bus.q9  = q_arr[9];
  assign bus.q10 = q_arr[10];
  assign bus.q11 = q_arr[11];
  assign bus.q12 = q_arr[12];
  assign bus.q13 = q_arr[13];
  assign bus.q14 = q_arr[14];
  assign bus.q15 = q_arr[15];

endmodule : register_bank
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank
// Description : Directed self-checking bench for register_bank.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank;
  import register_bank_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  word_t model [NREGS];

  register_bank_if bus ();

  register_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic word_t get_q(input int idx);
    word_t v;
    v = '0;
    case (idx)
      0:  v = bus.q0;
      1:  v = bus.q1;
      2:  v = bus.q2;
      3:  v = bus.q3;
      4:  v = bus.q4;
      5:  v = bus.q5;
      6:  v = bus.q6;
      7:  v = bus.q7;
      8:  v = bus.q8;
      9:  v = bus.q9;
      10: v = bus.q10;
      11: v = bus.q11;
      12: v = bus.q12;
      13: v = bus.q13;
      14: v = bus.q14;
      default: v = bus.q15;
    endcase
    return v;
  endfunction

  task automatic check_val(input string tag, input word_t obs, input word_t exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      check_val($sformatf("%s_q%0d", tag, i), get_q(i), model[i]);
    end
  endtask

  // Drive one cycle of stimulus, let one edge pass, then compare all outputs
  // against the expected contents after that edge.
  task automatic step(input string tag, input logic r, input sel_t sel,
                      input word_t din);
    @(negedge clk);
    rst        = r;
    bus.select = sel;
    bus.Din    = din;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREGS; i++) begin
      if (r) model[i] = '0;
      else if (sel[i]) model[i] = din;
    end
    check_all(tag);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b1;
    bus.select = '0;
    bus.Din    = '0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;

    // Reset with every write enabled: the write must be discarded.
    step("reset", 1'b1, 16'hFFFF, 32'hFFFF_FFFF);

    // Single writes.
    step("wr0", 1'b0, 16'h0001, 32'd10);
    check_val("wr0_q0_const", get_q(0), 32'd10);
    step("wr1", 1'b0, 16'h0002, 32'd11);
    check_val("wr1_q0_const", get_q(0), 32'd10);
    check_val("wr1_q1_const", get_q(1), 32'd11);

    // Idle cycles.
    for (int k = 0; k < 3; k++) step("idle", 1'b0, 16'h0000, 32'h1234_5678);

    // Only the Din present at the edge is captured.
    @(negedge clk);
    bus.select = 16'h0008;
    bus.Din    = 32'h0000_1111;
    #3;
    bus.Din    = 32'h0000_2222;
    @(posedge clk);
    #1;
    bus.select = 16'h0000;
    bus.Din    = 32'h0000_3333;
    model[3]   = 32'h0000_2222;
    #2;
    check_all("sample");
    check_val("sample_q3_const", get_q(3), 32'h0000_2222);
    @(posedge clk);
    #1;
    check_val("sample_hold_q3", get_q(3), 32'h0000_2222);

    // Multi-hot writes.
    step("multi2", 1'b0, 16'h0003, 32'd13);
    check_val("multi2_q1_const", get_q(1), 32'd13);
    check_val("multi2_q3_const", get_q(3), 32'h0000_2222);
    step("all", 1'b0, 16'hFFFF, 32'hDEAD_BEEF);
    check_val("all_q7_const", get_q(7), 32'hDEAD_BEEF);

    // Walking one across every register including the top index.
    for (int i = 0; i < NREGS; i++) begin
      step($sformatf("walk%0d", i), 1'b0, sel_t'(1) << i, word_t'(100 + i));
    end
    check_val("walk_q15_const", get_q(15), 32'd115);
    check_val("walk_q0_const", get_q(0), 32'd100);
    check_val("walk_q8_const", get_q(8), 32'd108);

    // Reset mid-stream beats a pending write, then operation resumes.
    step("rst_mid", 1'b1, 16'h0010, 32'd7);
    check_val("rst_mid_q4_const", get_q(4), 32'd0);
    step("resume", 1'b0, 16'h0010, 32'd7);
    check_val("resume_q4_const", get_q(4), 32'd7);
    check_val("resume_q5_const", get_q(5), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_register_bank
`default_nettype wire
